fixpt_div_sqrt_unit: RTL

//  Multi-cycle fixed-point arithmetic unit: rounded divide, reciprocal and integer square root.

---
 rtl/fixpt_pkg.sv | 28 ++
 rtl/fixpt_div_sqrt_unit_if.sv | 27 ++
 rtl/fixpt_round_sat.sv | 64 ++++++
 rtl/fixpt_div_sqrt_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fixpt_pkg.sv
// Shared types for the fixed-point divide / reciprocal / square-root unit.
// Holds the operation and FSM state encodings plus default iteration counts.
package fixpt_pkg;

    typedef enum logic [1:0] {
        MODE_DIV   = 2'b00,
        MODE_RECIP = 2'b01,
        MODE_SQRT  = 2'b10,
        MODE_ILL   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        ROUND = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam int DEF_W      = 16;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_RES_W  = 24;

    // Iteration counts at the default widths; the top derives its own
    // values from its parameters using the same formulas.
    localparam int DIV_ITERS  = DEF_W + DEF_FRAC_W + 1;
    localparam int SQRT_ITERS = DEF_W / 2;

endpackage

// File: rtl/fixpt_div_sqrt_unit_if.sv
// Controller-side handshake bundle for the divide / sqrt coprocessor.
// master: start, mode, op_a, op_b out; busy, done, result, sat in. slave: mirror.
interface fixpt_div_sqrt_unit_if #(
    parameter int W     = 16,
    parameter int RES_W = 24
);

    logic             start;
    logic [1:0]       mode;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             sat;

    modport master (
        output start, mode, op_a, op_b,
        input  busy, done, result, sat
    );

    modport slave (
        input  start, mode, op_a, op_b,
        output busy, done, result, sat
    );

endinterface

// File: rtl/fixpt_round_sat.sv
// Combinational rounding and saturation of the raw quotient / root.
// In: mode, quo (raw quotient), root, rem, div_zero. Out: result, sat.
module fixpt_round_sat
    import fixpt_pkg::*;
#(
    parameter int W      = 16,
    parameter int FRAC_W = 8,
    parameter int RES_W  = 24
) (
    input  mode_e              mode,
    input  logic [W+FRAC_W:0]  quo,
    input  logic [W/2-1:0]     root,
    input  logic [W:0]         rem,
    input  logic               div_zero,
    output logic [RES_W-1:0]   result,
    output logic               sat
);

    localparam int DW = W + FRAC_W + 1;
    localparam int HW = W / 2;
    // Wide enough for the rounded quotient and for an overflow bit.
    localparam int XW = (DW + 1 > RES_W + 1) ? DW + 1 : RES_W + 1;

    logic [XW-1:0] r_div;
    logic          ovf;
    logic          above;
    logic [HW:0]   r_sq;

    // Quotient carries one extra fraction bit; it is the half-LSB.
    always_comb begin
        r_div = XW'(quo >> 1) + XW'(quo[0]);
        ovf   = |r_div[XW-1:RES_W];
        above = rem > (W+1)'(root);
        r_sq  = {1'b0, root} + (HW+1)'(above);
    end

    always_comb begin
        result = '0;
        sat    = 1'b0;
        unique case (1'b1)
            (mode == MODE_DIV) || (mode == MODE_RECIP): begin
                if (div_zero || ovf) begin
                    result = '1;
                    sat    = 1'b1;
                end else begin
                    result = r_div[RES_W-1:0];
                end
            end
            mode == MODE_SQRT: begin
                if (r_sq[HW]) begin
                    result = RES_W'({HW{1'b1}});
                    sat    = 1'b1;
                end else begin
                    result = RES_W'(r_sq[HW-1:0]);
                end
            end
            default: begin
                result = '1;
                sat    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fixpt_div_sqrt_unit.sv
// Multi-cycle rounded divide, reciprocal and integer square root.
// Ports: clk, reset_n (async low), bus (slave: start/mode/op_a/op_b -> busy/done/result/sat).
module fixpt_div_sqrt_unit
    import fixpt_pkg::*;
#(
    parameter int W      = 16,
    parameter int FRAC_W = 8,
    parameter int RES_W  = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fixpt_div_sqrt_unit_if.slave   bus
);

    localparam int DW = W + FRAC_W + 1;
    localparam int HW = W / 2;
    localparam int SW = HW + 3;
    localparam int CW = $clog2(DW + 1);

    state_e           state;
    state_e           state_nx;
    mode_e            mode_q;
    mode_e            mode_in;
    logic [W-1:0]     dvs;
    logic [W:0]       rem;
    logic [W:0]       rem_nx;
    logic [DW-1:0]    quo;
    logic [DW-1:0]    quo_nx;
    logic [HW-1:0]    root;
    logic [HW-1:0]    root_nx;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             iter;
    logic             latch;
    logic             last;
    logic [W:0]       trial_d;
    logic             ge_d;
    logic [SW-1:0]    trial_s;
    logic [SW-1:0]    test_s;
    logic             ge_s;
    logic [RES_W-1:0] res_rnd;
    logic             sat_rnd;

    assign mode_in = mode_e'(bus.mode);
    assign last    = (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = (mode_in == MODE_ILL) ? ROUND : CALC;
            end
            CALC:  if (last) state_nx = ROUND;
            ROUND: state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC) || (state == ROUND);
        bus.done = (state == DONE);
        accept   = (state == IDLE) && bus.start;
        iter     = (state == CALC);
        latch    = (state == ROUND);
    end

    // One step of either restoring divide or digit-by-digit sqrt.
    // quo doubles as the dividend/radicand shifter; quotient bits enter at the LSB.
    always_comb begin
        trial_d = {rem[W-1:0], quo[DW-1]};
        ge_d    = trial_d >= {1'b0, dvs};
        trial_s = {rem[SW-3:0], quo[DW-1 -: 2]};
        test_s  = SW'({root, 2'b01});
        ge_s    = trial_s >= test_s;
        rem_nx  = rem;
        quo_nx  = quo;
        root_nx = root;
        if (mode_q == MODE_SQRT) begin
            rem_nx  = ge_s ? (W+1)'(trial_s - test_s) : (W+1)'(trial_s);
            quo_nx  = {quo[DW-3:0], 2'b00};
            root_nx = {root[HW-2:0], ge_s};
        end else begin
            rem_nx  = ge_d ? trial_d - {1'b0, dvs} : trial_d;
            quo_nx  = {quo[DW-2:0], ge_d};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MODE_DIV;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            root   <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mode_q <= mode_in;
            dvs    <= bus.op_b;
            rem    <= '0;
            root   <= '0;
            unique case (mode_in)
                MODE_SQRT: begin
                    quo <= {bus.op_a, {(DW-W){1'b0}}};
                    cnt <= CW'(HW - 1);
                end
                MODE_RECIP: begin
                    // 1<<(W-1) pre-shifted by FRAC_W+1 lands on the MSB.
                    quo <= DW'(1) << (DW - 1);
                    cnt <= CW'(DW - 1);
                end
                default: begin
                    quo <= DW'(bus.op_a) << (FRAC_W + 1);
                    cnt <= CW'(DW - 1);
                end
            endcase
        end else if (iter) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            root <= root_nx;
            cnt  <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.result <= '0;
            bus.sat    <= 1'b0;
        end else if (latch) begin
            bus.result <= res_rnd;
            bus.sat    <= sat_rnd;
        end
    end

    fixpt_round_sat #(
        .W      (W),
        .FRAC_W (FRAC_W),
        .RES_W  (RES_W)
    ) u_round (
        .mode     (mode_q),
        .quo      (quo),
        .root     (root),
        .rem      (rem),
        .div_zero (dvs == '0),
        .result   (res_rnd),
        .sat      (sat_rnd)
    );

endmodule
